fifo_burst_reader: RTL and testbench
====================================

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of every data word.
REQ-002 Parameter LEN_WIDTH, default 8: width of the burst length and remaining-count fields.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  burst request; accepted only when busy=0.
REQ-006 burst_len  input  LEN_WIDTH  number of words to pop; sampled on accepted start.
REQ-007 busy  output  1  high from the cycle after an accepted start through the done cycle.
REQ-008 done  output  1  single-cycle pulse at burst completion.
REQ-009 fifo_empty  input  1  upstream FIFO empty flag.
REQ-010 fifo_r_en  output  1  upstream FIFO pop strobe.
REQ-011 fifo_data_out  input  DATA_WIDTH  upstream FIFO read data; valid exactly one cycle after fifo_r_en.
REQ-012 m_valid  output  1  downstream word available.
REQ-013 m_ready  input  1  downstream accepts word.
REQ-014 m_data  output  DATA_WIDTH  downstream word; stable while m_valid=1 and m_ready=0.

Function
REQ-015 The FSM SHALL have states IDLE, READ, DRAIN, DONE.
REQ-016 Transitions: IDLE->READ on start with burst_len!=0; IDLE->DONE on start with burst_len==0; READ->DRAIN on the cycle the last pop issues; DRAIN->DONE when no read is in flight and the buffer is empty; DONE->IDLE unconditionally.
REQ-017 A start that arrives while busy=1 SHALL be ignored without side effects.
REQ-018 fifo_r_en SHALL be asserted only when all of the following hold: state==READ, fifo_empty==0, remaining!=0, and in-flight reads plus buffered words is less than 2.
REQ-019 remaining SHALL load burst_len on start and decrement by 1 on each fifo_r_en cycle, with no wrap below 0.
REQ-020 Each word SHALL be captured into the 2-entry output buffer the cycle after its fifo_r_en.
REQ-021 The buffer SHALL preserve word order.
REQ-022 If a push and a pop occur in the same cycle, the buffer SHALL process both.
REQ-023 A downstream transfer SHALL occur exactly when m_valid && m_ready.
REQ-024 m_valid SHALL equal buffer-not-empty, and m_data SHALL equal the buffer head.
REQ-025 With m_ready held at 1 and fifo_empty held at 0, throughput SHALL be 1 word per cycle.
REQ-026 First-word latency SHALL be 2 cycles from the start edge: the r_en cycle, then the capture cycle.
REQ-027 While fifo_empty=1 in READ, the block SHALL stall with fifo_r_en=0 and SHALL NOT time out.
REQ-028 done SHALL be high only in DONE, which follows the cycle of the last downstream transfer.
REQ-029 busy SHALL drop in the cycle after done.
REQ-030 The block SHALL never pop more than burst_len words per burst.
REQ-031 The block SHALL never overflow its 2-entry buffer.

Reset
REQ-032 On rst_n=0, the block SHALL immediately force state=IDLE, remaining=0, buffer empty, and in-flight flag=0.
REQ-033 On rst_n=0, the block SHALL immediately drive busy=0, done=0, fifo_r_en=0, m_valid=0, m_data=0.
REQ-034 A reset during a burst SHALL discard buffered and in-flight words without replay.
REQ-035 After reset releases, the first cycle SHALL accept a new start.

Structure
REQ-036 Package fifo_pkg SHALL hold the state enum (IDLE, READ, DRAIN, DONE) and the default DATA_WIDTH/LEN_WIDTH constants.
REQ-037 The 2-entry ordered output buffer SHALL be a sub-module fifo_skid_buf, parameterised by DATA_WIDTH.
REQ-038 fifo_skid_buf SHALL use ports push/push_data/pop/valid/head/count on the same clk/rst_n.

Verification
REQ-039 Simple burst: burst_len=4, FIFO holds 0x11..0x14, m_ready=1 -> m_data 0x11,0x12,0x13,0x14 on consecutive cycles from start+2; done one cycle later; exactly 4 r_en pulses.
REQ-040 Backpressure: burst_len=3, m_ready=0 for cycles 2..6 -> at most 2 r_en before stall; m_data 0xA0 held stable; all 3 words delivered in order; done after the third transfer.
REQ-041 Empty FIFO: burst_len=2, fifo_empty=1 for 5 cycles, then data 0x55, 0x66 -> no r_en while empty; 0x55, 0x66 delivered; busy high throughout.
REQ-042 Zero length and overlap: start with burst_len=0 -> done on next cycle with no r_en and no m_valid; a start while busy with burst_len=9 -> ignored, remaining unchanged.
REQ-043 Reset mid-burst: rst_n low after 2 of 5 words -> all outputs 0 that cycle; after release, a start with burst_len=1 completes normally.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and default sizes for the FIFO burst reader and its output buffer.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_LEN_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage : fifo_pkg

// File: rtl/fifo_burst_reader_if.sv
// Upstream FIFO read port plus downstream valid/ready stream, bundled for the burst reader.
interface fifo_burst_reader_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic                  fifo_empty;
  logic                  fifo_r_en;
  logic [DATA_WIDTH-1:0] fifo_data_out;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    input  fifo_empty, fifo_data_out, m_ready,
    output fifo_r_en, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_data_out, m_ready,
    input  fifo_r_en, m_valid, m_data
  );

endinterface : fifo_burst_reader_if

// File: rtl/fifo_skid_buf.sv
// Two-entry ordered buffer; push and pop may happen in the same cycle.
// The caller guarantees no push when full and no pop when empty.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] head,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage is reset too, so the exposed head reads zero while in reset.
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign valid = (count_q != 2'd0);
  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule : fifo_skid_buf

// File: rtl/fifo_burst_reader.sv
// Pops burst_len words from an upstream FIFO (one-cycle read latency) and streams them
// downstream through a two-entry buffer, with done/busy framing around each burst.
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] burst_len,
  output logic                 busy,
  output logic                 done,
  fifo_burst_reader_if.master  bus
);

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic                  inflight_q;

  logic                  buf_valid;
  logic [DATA_WIDTH-1:0] buf_head;
  logic [1:0]            buf_count;
  logic                  pop;
  logic [1:0]            occupancy;
  logic                  rd_en;
  logic                  buf_emptying;

  fifo_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (bus.fifo_data_out),
    .pop       (pop),
    .valid     (buf_valid),
    .head      (buf_head),
    .count     (buf_count)
  );

  assign pop = buf_valid && bus.m_ready;

  // Buffered words are counted after this cycle's downstream pop, which keeps the
  // buffer from overflowing while still allowing one pop per cycle when unstalled.
  assign occupancy = buf_count + {1'b0, inflight_q} - {1'b0, pop};

  assign rd_en = (state_q == READ) && !bus.fifo_empty &&
                 (remaining_q != '0) && (occupancy < 2'd2);

  // Finish in the same cycle the final word leaves, so done follows the last transfer.
  assign buf_emptying = !inflight_q &&
                        ((buf_count == 2'd0) || ((buf_count == 2'd1) && pop));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          remaining_d = burst_len;
          state_d     = (burst_len == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (rd_en && (remaining_q == LEN_WIDTH'(1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (buf_emptying) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rd_en) begin
      remaining_d = remaining_q - LEN_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      inflight_q  <= rd_en;
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign bus.fifo_r_en = rd_en;
  assign bus.m_valid   = buf_valid;
  assign bus.m_data    = buf_head;

endmodule : fifo_burst_reader

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: a cycle table for the plain, zero-length and
// overlapping-start bursts, plus hand sequences for backpressure, empty stalls and reset.
module tb_fifo_burst_reader;

  localparam int DW = 32;
  localparam int LW = 8;

  typedef struct {
    bit          st;
    logic [LW-1:0] len;
    bit          rdy;
    bit          busy;
    bit          done;
    bit          ren;
    bit          mv;
    logic [DW-1:0] md;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [LW-1:0] burst_len;
  logic          busy;
  logic          done;

  fifo_burst_reader_if #(.DATA_WIDTH(DW)) bus ();

  fifo_burst_reader #(
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .burst_len (burst_len),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            ren_total = 0;
  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  vec_t          vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input bit st, input logic [LW-1:0] len, input bit rdy,
                         input bit b, input bit d, input bit r, input bit mv,
                         input logic [DW-1:0] md);
    vec_t v;
    v = '{st, len, rdy, b, d, r, mv, md};
    vecs.push_back(v);
  endtask

  // Present this cycle's inputs (FIFO flag from the model queue) and let outputs settle.
  task automatic drive(input bit st, input logic [LW-1:0] len, input bit rdy, input bit stl);
    start         = st;
    burst_len     = len;
    bus.m_ready   = rdy;
    bus.fifo_empty = stl || (fq.size() == 0);
    #1;
  endtask

  // Advance one clock; the FIFO model returns data one cycle after a pop strobe.
  task automatic tick();
    bit prev_ren;
    prev_ren = bus.fifo_r_en;
    if (prev_ren) ren_total++;
    @(posedge clk);
    #1;
    if (prev_ren && fq.size() > 0) bus.fifo_data_out = fq.pop_front();
  endtask

  // Run one burst with m_ready low in [rlo,rhi] and the FIFO forced empty in [slo,shi];
  // expected words are taken from exp_q.
  task automatic run_burst(input string tag, input logic [LW-1:0] len,
                           input int rlo, input int rhi, input int slo, input int shi);
    int            got = 0;
    int            ren_n = 0;
    int            ren_early = 0;
    int            last_xfer = -1;
    bit            done_seen = 0;
    bit            holding = 0;
    logic [DW-1:0] held = '0;
    bit            rdy, stl;
    drive(1'b1, len, 1'b1, 1'b0);
    tick();
    for (int cyc = 1; cyc < 200 && !done_seen; cyc++) begin
      rdy = !(cyc >= rlo && cyc <= rhi);
      stl = (cyc >= slo && cyc <= shi);
      drive(1'b0, '0, rdy, stl);
      check($sformatf("%s busy c%0d", tag, cyc), busy, 1'b1);
      if (stl) check($sformatf("%s r_en while empty c%0d", tag, cyc), bus.fifo_r_en, 1'b0);
      if (bus.fifo_r_en) begin
        ren_n++;
        if (cyc <= rhi) ren_early++;
      end
      if (holding) check($sformatf("%s m_data held c%0d", tag, cyc), bus.m_data, held);
      holding = bus.m_valid && !rdy;
      held    = bus.m_data;
      if (bus.m_valid && rdy) begin
        if (got < exp_q.size())
          check($sformatf("%s word%0d", tag, got), bus.m_data, exp_q[got]);
        got++;
        last_xfer = cyc;
      end
      if (done) begin
        done_seen = 1;
        check($sformatf("%s done cycle", tag), cyc, last_xfer + 1);
      end
      tick();
    end
    check($sformatf("%s done seen", tag), done_seen, 1'b1);
    check($sformatf("%s words", tag), got, exp_q.size());
    check($sformatf("%s r_en pulses", tag), ren_n, len);
    if (rhi >= rlo) check($sformatf("%s r_en before stall <=2", tag), ren_early <= 2, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0);
    check($sformatf("%s busy drops", tag), busy, 1'b0);
    check($sformatf("%s done pulse", tag), done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int xfers;
    rst_n             = 1'b0;
    start             = 1'b0;
    burst_len         = '0;
    bus.m_ready       = 1'b0;
    bus.fifo_empty    = 1'b1;
    bus.fifo_data_out = '0;
    #3;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset r_en", bus.fifo_r_en, 1'b0);
    check("reset m_valid", bus.m_valid, 1'b0);
    check("reset m_data", bus.m_data, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table: 4-word burst, zero-length burst, 2-word burst with starts while busy.
    fq.push_back(32'h11); fq.push_back(32'h12); fq.push_back(32'h13);
    fq.push_back(32'h14); fq.push_back(32'h21); fq.push_back(32'h22);
    //      st len rdy busy done ren mv md
    add_vec(1, 4, 1, 0, 0, 0, 0, 32'h0);
    add_vec(0, 0, 1, 1, 0, 1, 0, 32'h0);
    add_vec(0, 0, 1, 1, 0, 1, 0, 32'h0);
    add_vec(0, 0, 1, 1, 0, 1, 1, 32'h11);
    add_vec(0, 0, 1, 1, 0, 1, 1, 32'h12);
    add_vec(0, 0, 1, 1, 0, 0, 1, 32'h13);
    add_vec(0, 0, 1, 1, 0, 0, 1, 32'h14);
    add_vec(0, 0, 1, 1, 1, 0, 0, 32'h0);
    add_vec(0, 0, 1, 0, 0, 0, 0, 32'h0);
    add_vec(1, 0, 1, 0, 0, 0, 0, 32'h0);
    add_vec(0, 0, 1, 1, 1, 0, 0, 32'h0);
    add_vec(0, 0, 1, 0, 0, 0, 0, 32'h0);
    add_vec(1, 2, 1, 0, 0, 0, 0, 32'h0);
    add_vec(1, 9, 1, 1, 0, 1, 0, 32'h0);
    add_vec(1, 9, 1, 1, 0, 1, 0, 32'h0);
    add_vec(0, 0, 1, 1, 0, 0, 1, 32'h21);
    add_vec(0, 0, 1, 1, 0, 0, 1, 32'h22);
    add_vec(1, 9, 1, 1, 1, 0, 0, 32'h0);
    add_vec(0, 0, 1, 0, 0, 0, 0, 32'h0);
    add_vec(0, 0, 1, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].st, vecs[i].len, vecs[i].rdy, 1'b0);
      check($sformatf("vec%0d busy", i), busy, vecs[i].busy);
      check($sformatf("vec%0d done", i), done, vecs[i].done);
      check($sformatf("vec%0d r_en", i), bus.fifo_r_en, vecs[i].ren);
      check($sformatf("vec%0d m_valid", i), bus.m_valid, vecs[i].mv);
      if (vecs[i].mv) check($sformatf("vec%0d m_data", i), bus.m_data, vecs[i].md);
      tick();
    end
    check("table r_en total", ren_total, 6);

    // Backpressure: m_ready low for cycles 2..6.
    fq.push_back(32'hA0); fq.push_back(32'hA1); fq.push_back(32'hA2);
    exp_q = {32'hA0, 32'hA1, 32'hA2};
    run_burst("bp", 3, 2, 6, -1, -2);

    // Upstream FIFO empty for the first five cycles of the burst.
    fq.push_back(32'h55); fq.push_back(32'h66);
    exp_q = {32'h55, 32'h66};
    run_burst("empty", 2, -1, -2, 1, 5);

    // Reset after two of five words have been delivered.
    fq.delete();
    for (int i = 0; i < 5; i++) fq.push_back(32'hB0 + i);
    drive(1'b1, 5, 1'b1, 1'b0);
    tick();
    xfers = 0;
    for (int c = 0; c < 20 && xfers < 2; c++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      if (bus.m_valid) xfers++;
      tick();
    end
    check("rst words before reset", xfers, 2);
    rst_n = 1'b0;
    #1;
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst r_en", bus.fifo_r_en, 1'b0);
    check("rst m_valid", bus.m_valid, 1'b0);
    check("rst m_data", bus.m_data, '0);
    fq.delete();
    fq.push_back(32'hC1);
    tick();
    rst_n = 1'b1;
    exp_q = {32'hC1};
    run_burst("post_rst", 1, -1, -2, -1, -2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fifo_burst_reader
